// File: rtl/number_display_sequencer_pkg.sv
// Shared types, segment encodings and FSM states for the decimal display sequencer.
// Segment bit order, MSB to LSB: middle, bottom_left, bottom, bottom_right, top_right, top, top_left.
package number_display_sequencer_pkg;

  typedef logic [15:0] UInt16;
  typedef logic [3:0]  Digit;
  typedef logic [6:0]  Segments7;

  localparam Digit EmptyDigit = 4'hF;

  localparam Segments7 SEG_0     = 7'b0111111;
  localparam Segments7 SEG_1     = 7'b0001100;
  localparam Segments7 SEG_2     = 7'b1110110;
  localparam Segments7 SEG_3     = 7'b1011110;
  localparam Segments7 SEG_4     = 7'b1001101;
  localparam Segments7 SEG_5     = 7'b1011011;
  localparam Segments7 SEG_6     = 7'b1111011;
  localparam Segments7 SEG_7     = 7'b0001110;
  localparam Segments7 SEG_8     = 7'b1111111;
  localparam Segments7 SEG_9     = 7'b1011111;
  localparam Segments7 SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    COMMIT
  } seq_state_t;

  function automatic Segments7 seg_decode(input Digit d);
    case (d)
      4'd0:    seg_decode = SEG_0;
      4'd1:    seg_decode = SEG_1;
      4'd2:    seg_decode = SEG_2;
      4'd3:    seg_decode = SEG_3;
      4'd4:    seg_decode = SEG_4;
      4'd5:    seg_decode = SEG_5;
      4'd6:    seg_decode = SEG_6;
      4'd7:    seg_decode = SEG_7;
      4'd8:    seg_decode = SEG_8;
      4'd9:    seg_decode = SEG_9;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/number_display_sequencer_if.sv
// Request handshake between a value producer and the display sequencer.
interface number_display_sequencer_if;
  import number_display_sequencer_pkg::*;

  logic  in_valid;
  UInt16 in_number;
  logic  in_ready;

  modport master (output in_valid, output in_number, input  in_ready);
  modport slave  (input  in_valid, input  in_number, output in_ready);

endinterface

// File: rtl/number_display_sequencer_digit_stage.sv
// Shared divide-by-10 / segment-decode stage; one display position per evaluation.
module number_display_sequencer_digit_stage
  import number_display_sequencer_pkg::*;
(
  input  UInt16    rem,
  input  logic     force_zero,
  output UInt16    next_rem,
  output Digit     digit,
  output Segments7 pattern
);

  always_comb begin
    next_rem = rem / 16'd10;
    if (rem != '0) begin
      digit = Digit'(rem % 16'd10);
    end else if (force_zero) begin
      digit = 4'd0;
    end else begin
      digit = EmptyDigit;
    end
    pattern = seg_decode(digit);
  end

endmodule

// File: rtl/number_display_sequencer.sv
// Decimal display sequencer: converts one digit per cycle into a shadow buffer,
// then commits the whole bank at once so partial results are never visible.
module number_display_sequencer
  import number_display_sequencer_pkg::*;
#(
  parameter int unsigned DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  number_display_sequencer_if.slave req,
  output logic [DIGITS*7-1:0]     segments,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  seq_state_t          r_state;
  seq_state_t          w_next_state;
  UInt16               r_rem;
  logic [IDX_W-1:0]    r_idx;
  logic [DIGITS*7-1:0] r_shadow;
  logic [DIGITS*7-1:0] r_segments;
  logic                r_done;
  logic                r_overflow;

  UInt16    w_next_rem;
  Digit     w_digit;
  Segments7 w_pattern;
  Segments7 w_seg;
  logic     w_force_zero;
  logic     w_last;

  // Position 0 with a zero remainder means the accepted value itself was zero.
  assign w_force_zero = (r_idx == '0) && (r_rem == '0);
  assign w_last       = (r_idx == IDX_W'(DIGITS - 1));
  assign w_seg        = (w_digit == EmptyDigit) ? SEG_BLANK : w_pattern;

  number_display_sequencer_digit_stage u_stage (
    .rem        (r_rem),
    .force_zero (w_force_zero),
    .next_rem   (w_next_rem),
    .digit      (w_digit),
    .pattern    (w_pattern)
  );

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (req.in_valid) w_next_state = CONVERT;
      CONVERT: if (w_last)       w_next_state = COMMIT;
      COMMIT:                    w_next_state = IDLE;
      default:                   w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rem      <= '0;
      r_idx      <= '0;
      r_shadow   <= '0;
      r_segments <= '0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (req.in_valid) begin
            r_rem    <= req.in_number;
            r_idx    <= '0;
            r_shadow <= '0;
          end
        end
        CONVERT: begin
          for (int unsigned k = 0; k < DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) r_shadow[7*k +: 7] <= w_seg;
          end
          r_rem <= w_next_rem;
          r_idx <= r_idx + 1'b1;
        end
        COMMIT: begin
          r_segments <= r_shadow;
          r_overflow <= (r_rem != '0);
          r_done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign req.in_ready = (r_state == IDLE);
  assign busy         = (r_state != IDLE);
  assign done         = r_done;
  assign segments     = r_segments;
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_number_display_sequencer.sv
// Directed bench: a 5-digit and a 3-digit sequencer driven by a vector table plus
// hand-written reset and back-pressure sequences.
module tb_number_display_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  number_display_sequencer_if if5();
  number_display_sequencer_if if3();

  logic [34:0] seg5;
  logic [20:0] seg3;
  logic        busy5, done5, ovf5;
  logic        busy3, done3, ovf3;

  number_display_sequencer #(.DIGITS(5)) dut5 (
    .clk      (clk),
    .rst      (rst),
    .req      (if5),
    .segments (seg5),
    .busy     (busy5),
    .done     (done5),
    .overflow (ovf5)
  );

  number_display_sequencer #(.DIGITS(3)) dut3 (
    .clk      (clk),
    .rst      (rst),
    .req      (if3),
    .segments (seg3),
    .busy     (busy3),
    .done     (done3),
    .overflow (ovf3)
  );

  localparam logic [6:0] PB = 7'b0000000;
  localparam logic [6:0] P0 = 7'b0111111;
  localparam logic [6:0] P1 = 7'b0001100;
  localparam logic [6:0] P2 = 7'b1110110;
  localparam logic [6:0] P3 = 7'b1011110;
  localparam logic [6:0] P4 = 7'b1001101;
  localparam logic [6:0] P5 = 7'b1011011;
  localparam logic [6:0] P6 = 7'b1111011;
  localparam logic [6:0] P7 = 7'b0001110;
  localparam logic [6:0] P9 = 7'b1011111;

  typedef struct {
    logic [15:0] num;
    logic [34:0] exp5;
    logic        ovf5;
    logic [20:0] exp3;
    logic        ovf3;
  } vec_t;

  vec_t vecs[8];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives the same value into both sequencers and checks done/segments at the fixed latency.
  task automatic request(input vec_t v);
    @(negedge clk);
    chk("ready5_pre", 64'(if5.in_ready), 64'(1'b1));
    chk("ready3_pre", 64'(if3.in_ready), 64'(1'b1));
    if5.in_valid = 1'b1; if5.in_number = v.num;
    if3.in_valid = 1'b1; if3.in_number = v.num;
    @(negedge clk);
    if5.in_valid = 1'b0;
    if3.in_valid = 1'b0;
    chk("busy5", 64'(busy5), 64'(1'b1));
    chk("busy3", 64'(busy3), 64'(1'b1));
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 4) begin
        chk("done3", 64'(done3), 64'(1'b1));
        chk("seg3",  64'(seg3),  64'(v.exp3));
        chk("ovf3",  64'(ovf3),  64'(v.ovf3));
      end else begin
        chk("done3_quiet", 64'(done3), 64'(1'b0));
      end
      if (c == 6) begin
        chk("done5", 64'(done5), 64'(1'b1));
        chk("seg5",  64'(seg5),  64'(v.exp5));
        chk("ovf5",  64'(ovf5),  64'(v.ovf5));
      end else begin
        chk("done5_quiet", 64'(done5), 64'(1'b0));
      end
    end
  endtask

  initial begin
    vec_t h;
    logic saw_done;
    logic [34:0] held;

    rst = 1'b1;
    if5.in_valid = 1'b0; if5.in_number = '0;
    if3.in_valid = 1'b0; if3.in_number = '0;

    vecs[0] = '{16'd1234,  {PB,P1,P2,P3,P4}, 1'b0, {P2,P3,P4}, 1'b1};
    vecs[1] = '{16'd0,     {PB,PB,PB,PB,P0}, 1'b0, {PB,PB,P0}, 1'b0};
    vecs[2] = '{16'd65535, {P6,P5,P5,P3,P5}, 1'b0, {P5,P3,P5}, 1'b1};
    vecs[3] = '{16'd10,    {PB,PB,PB,P1,P0}, 1'b0, {PB,P1,P0}, 1'b0};
    vecs[4] = '{16'd100,   {PB,PB,P1,P0,P0}, 1'b0, {P1,P0,P0}, 1'b0};
    vecs[5] = '{16'd1000,  {PB,P1,P0,P0,P0}, 1'b0, {P0,P0,P0}, 1'b1};
    vecs[6] = '{16'd7,     {PB,PB,PB,PB,P7}, 1'b0, {PB,PB,P7}, 1'b0};
    vecs[7] = '{16'd12345, {P1,P2,P3,P4,P5}, 1'b0, {P3,P4,P5}, 1'b1};

    #12;
    chk("rst_seg5",   64'(seg5),         64'(0));
    chk("rst_seg3",   64'(seg3),         64'(0));
    chk("rst_ready5", 64'(if5.in_ready), 64'(1'b1));
    chk("rst_busy5",  64'(busy5),        64'(1'b0));
    chk("rst_done5",  64'(done5),        64'(1'b0));
    chk("rst_ovf3",   64'(ovf3),         64'(1'b0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) request(vecs[i]);

    // Overflow on the 3-digit unit clears on the next commit (7 after 12345).
    h = '{16'd7, {PB,PB,PB,PB,P7}, 1'b0, {PB,PB,P7}, 1'b0};
    request(h);
    request(vecs[7]);

    // Reset asserted mid-conversion of 1234 (before the second CONVERT edge).
    @(negedge clk);
    if5.in_valid = 1'b1; if5.in_number = 16'd1234;
    if3.in_valid = 1'b1; if3.in_number = 16'd1234;
    @(negedge clk);
    if5.in_valid = 1'b0; if3.in_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_seg5",   64'(seg5),         64'(0));
    chk("mid_rst_seg3",   64'(seg3),         64'(0));
    chk("mid_rst_ready5", 64'(if5.in_ready), 64'(1'b1));
    chk("mid_rst_ready3", 64'(if3.in_ready), 64'(1'b1));
    chk("mid_rst_busy5",  64'(busy5),        64'(1'b0));
    chk("mid_rst_ovf3",   64'(ovf3),         64'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done5 || done3) saw_done = 1'b1;
    end
    chk("mid_rst_no_done", 64'(saw_done), 64'(1'b0));
    chk("mid_rst_seg5_after", 64'(seg5), 64'(0));

    request(h);

    // 42 then 99 held on in_valid throughout busy (5-digit unit only).
    held = {PB,PB,PB,PB,P7};
    @(negedge clk);
    if5.in_valid = 1'b1; if5.in_number = 16'd42;
    @(negedge clk);
    if5.in_number = 16'd99;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c < 6) begin
        chk("hold_seg_old",  64'(seg5),         64'(held));
        chk("hold_not_rdy",  64'(if5.in_ready), 64'(1'b0));
        chk("hold_no_done",  64'(done5),        64'(1'b0));
      end else begin
        chk("hold_done42",   64'(done5),        64'(1'b1));
        chk("hold_seg42",    64'(seg5),         64'({PB,PB,PB,P4,P2}));
        chk("hold_rdy_after",64'(if5.in_ready), 64'(1'b1));
      end
    end
    @(negedge clk);
    chk("hold_accept99", 64'(busy5), 64'(1'b1));
    if5.in_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c < 6) begin
        chk("hold_seg42_kept", 64'(seg5), 64'({PB,PB,PB,P4,P2}));
      end else begin
        chk("hold_done99", 64'(done5), 64'(1'b1));
        chk("hold_seg99",  64'(seg5),  64'({PB,PB,PB,P9,P9}));
        chk("hold_ovf99",  64'(ovf5),  64'(1'b0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
